// File: rtl/cr_word_bridge.sv
// cr_word_bridge: splits a 32-bit CPU word access in the 0x80xxxxxx window
// into two 16-bit CellularRAM accesses (low half first, then high half) and
// returns the word with a single-cycle cpu_ready pulse.
// Optional feature macro: CR_BRIDGE_TIMEOUT_EN enables a per-phase watchdog
// that forces completion (read data 32'hFFFFFFFF) after TIMEOUT cycles.
module cr_word_bridge #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_q;
  logic [31:0] rdata_q;

  logic req_valid;
  logic abort;
  logic busy;
  logic timeout;
  logic timeout_hit;

  // Word-aligned address bits and the upper controller data lane carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[1:0], bus_rdata[31:16]};

  assign req_valid = (cpu_rd || cpu_wr) && (cpu_addr[31:24] == 8'h80);
  assign abort     = !cpu_rd && !cpu_wr;
  assign busy      = (state_q == S_LO) || (state_q == S_HI);

`ifdef CR_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT));

  // Phase counter: restarts whenever the state changes, counts while a phase waits.
  always_ff @(posedge clk) begin
    if (!Nrst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  // A waiting phase gives up only if the controller has not answered this cycle.
  assign timeout_hit = busy && !abort && !bus_ready && timeout;

  // Next-state selection; a dropped request wins over a completing halfword.
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_LO;
      S_LO: begin
        if (abort)          state_d = S_IDLE;
        else if (bus_ready) state_d = S_HI;
        else if (timeout)   state_d = S_DONE;
      end
      S_HI: begin
        if (abort)                     state_d = S_IDLE;
        else if (bus_ready || timeout) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request latch and halfword assembly registers.
  always_ff @(posedge clk) begin
    if (!Nrst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        addr_q  <= {cpu_addr[31:2], 2'b00};
        wr_q    <= cpu_wr;
        wdata_q <= cpu_wdata;
      end
      if (state_q == S_LO && !abort && bus_ready) begin
        lo_q <= bus_rdata[15:0];
      end
      if (state_q == S_HI && !abort && bus_ready) begin
        rdata_q <= {bus_rdata[15:0], lo_q};
      end else if (timeout_hit) begin
        rdata_q <= wr_q ? 32'h0 : 32'hFFFF_FFFF;
      end
    end
  end

  // Controller-facing outputs derive only from state and latched request.
  assign bus_addr  = (state_q == S_LO) ? addr_q :
                     (state_q == S_HI) ? addr_q + 32'd2 : 32'h0;
  assign bus_rd    = busy && !wr_q;
  assign bus_wr    = busy && wr_q;
  assign bus_wdata = (busy && wr_q) ?
                     {16'h0, (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0]} : 32'h0;

  // CPU-facing completion.
  assign cpu_ready = (state_q == S_DONE);
  assign cpu_rdata = (state_q == S_DONE && !wr_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_cr_word_bridge.sv
// Directed testbench for cr_word_bridge with a CellularRAM-like responder that
// raises bus_ready on the third cycle of a stable strobed address.
module tb_cr_word_bridge;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int checks = 0;
  int errors = 0;

  // Responder model state.
  logic        model_en = 1'b1;
  logic [15:0] mem [0:127];
  logic [31:0] last_addr = 32'h0;
  logic        last_valid = 1'b0;
  int          stab = 0;
  logic [47:0] wlog [$];

  cr_word_bridge #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  // Upper lane carries junk so the bridge must use only [15:0].
  assign bus_rdata = {16'hDEAD, mem[bus_addr[7:1]]};
  assign bus_ready = model_en && (bus_rd || bus_wr) && last_valid &&
                     (bus_addr == last_addr) && (stab == 2);

  always @(posedge clk) begin
    if (bus_wr && bus_ready) wlog.push_back({bus_addr, bus_wdata[15:0]});
    if (bus_rd || bus_wr) begin
      if (last_valid && bus_addr == last_addr) stab <= stab + 1;
      else                                     stab <= 1;
      last_addr  <= bus_addr;
      last_valid <= 1'b1;
    end else begin
      stab       <= 0;
      last_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " strobes/ready"}, {29'h0, cpu_ready, bus_rd, bus_wr}, 32'h0);
    check({tag, " rdata"}, cpu_rdata, 32'h0);
  endtask

  // One full word access against the 3-cycle responder; caller sits on a negedge.
  task automatic transact(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdata);
    logic [31:0] base;
    base      = {a[31:2], 2'b00};
    cpu_addr  = a;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = wd;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("%s ready c%0d", tag, c), 32'(cpu_ready), 32'(c == 7));
      if (c == 1 || c == 4) begin
        check($sformatf("%s addr c%0d", tag, c), bus_addr, (c == 1) ? base : base + 32'd2);
        check($sformatf("%s strobe c%0d", tag, c), {30'h0, bus_rd, bus_wr}, {30'h0, !wr, wr});
        if (wr)
          check($sformatf("%s wdata c%0d", tag, c), bus_wdata,
                (c == 1) ? {16'h0, wd[15:0]} : {16'h0, wd[31:16]});
      end
      if (c == 2) begin
        cpu_addr  = ~a;
        cpu_wdata = ~wd;
      end
      if (c == 7) begin
        check({tag, " rdata"}, cpu_rdata, exp_rdata);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
      end
    end
    @(negedge clk);
    check_idle({tag, " after"});
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[8] = 16'h1234;  // 0x80000010
    mem[9] = 16'hABCD;  // 0x80000012

    Nrst      = 1'b0;
    cpu_addr  = 32'h0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset bus_wdata", bus_wdata, 32'h0);
    Nrst = 1'b1;
    @(negedge clk);

    // Basic read, then back-to-back write.
    transact("rd10", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'hABCD_1234);
    wlog.delete();
    transact("wr20", 1'b0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 32'h0);
    check("wr20 count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("wr20 lo addr", wlog[0][47:16], 32'h8000_0020);
      check("wr20 lo data", {16'h0, wlog[0][15:0]}, 32'h0000_F00D);
      check("wr20 hi addr", wlog[1][47:16], 32'h8000_0022);
      check("wr20 hi data", {16'h0, wlog[1][15:0]}, 32'h0000_CAFE);
    end

    // Read and write both high: treated as a write.
    wlog.delete();
    transact("rw30", 1'b1, 1'b1, 32'h8000_0030, 32'h5555_AAAA, 32'h0);
    check("rw30 count", 32'(wlog.size()), 32'd2);

    // Unaligned address is word-aligned.
    transact("rd13", 1'b1, 1'b0, 32'h8000_0013, 32'h0, 32'hABCD_1234);

    // Outside the window: nothing happens.
    cpu_addr = 32'h4000_0000;
    cpu_rd   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check_idle($sformatf("oor c%0d", c));
    end
    cpu_rd = 1'b0;
    @(negedge clk);

    // Abort in HI by dropping cpu_rd.
    cpu_addr = 32'h8000_0030;
    cpu_rd   = 1'b1;
    repeat (4) @(negedge clk);
    check("abort hi addr", bus_addr, 32'h8000_0032);
    check("abort hi rd", 32'(bus_rd), 32'd1);
    cpu_rd = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_idle($sformatf("abort c%0d", c));
    end

    // Reset during LO.
    cpu_addr = 32'h8000_0010;
    cpu_rd   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst lo rd", 32'(bus_rd), 32'd1);
    Nrst   = 1'b0;
    cpu_rd = 1'b0;
    @(negedge clk);
    check_idle("rst next");
    check("rst bus_addr", bus_addr, 32'h0);
    Nrst = 1'b1;
    @(negedge clk);

    // Controller never answers.
    model_en = 1'b0;
    cpu_addr = 32'h8000_0040;
    cpu_rd   = 1'b1;
`ifdef CR_BRIDGE_TIMEOUT_EN
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("to ready c%0d", c), 32'(cpu_ready), 32'(c == 10));
      if (c == 10) begin
        check("to rdata", cpu_rdata, 32'hFFFF_FFFF);
        cpu_rd = 1'b0;
      end
    end
`else
    bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!(bus_rd === 1'b1 && cpu_ready === 1'b0 && bus_addr === 32'h8000_0040)) bad++;
    end
    check("stuck in lo", 32'(bad), 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk);
    check_idle("stuck drop");
`endif
    model_en = 1'b1;
    @(negedge clk);

    // Recovery read.
    transact("rd10b", 1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'hABCD_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
